mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// CPU bus controller: decodes requests onto RAM, ROM and peripheral ports with configurable wait states.
// Define MEM_BUS_TIMEOUT_EN to compile in the peripheral-access timeout.
module mem_bus_ctrl #(
    parameter int RAM_WAIT   = 0,
    parameter int ROM_WAIT   = 1,
    parameter int IO_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_op,
    output logic        cpu_mem_rdy,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_do,
    input  logic [3:0]  cpu_wren,
    output logic [31:0] cpu_di,
    output logic        ram_en,
    output logic [13:0] ram_adr,
    output logic [3:0]  ram_wren,
    output logic [31:0] ram_do,
    input  logic [31:0] ram_di,
    output logic        rom_en,
    output logic [13:0] rom_adr,
    input  logic [31:0] rom_di,
    output logic        io_valid,
    output logic [7:0]  io_adr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb,
    input  logic        io_ready,
    input  logic [31:0] io_rdata,
    output logic        bus_err
);

    localparam int WAIT_MAX = (RAM_WAIT > ROM_WAIT) ? RAM_WAIT : ROM_WAIT;
    localparam int WW       = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_MEM, S_WAIT, S_IO, S_RESP} state_t;
    typedef enum logic [1:0] {R_RAM, R_ROM, R_IO, R_NONE} region_t;

    state_t        state, next_state;
    region_t       dec_region, region_q;
    logic [13:0]   word_q;
    logic [31:0]   data_q;
    logic [3:0]    wren_q;
    logic [WW-1:0] wait_cnt, wait_lim;
    logic          bad_req, wait_done, is_write;
    logic          unused_adr_bits;

    assign unused_adr_bits = ^cpu_adr[1:0];

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TW = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT);
    logic [TW-1:0] io_cnt;
    logic          timeout_hit;
    assign timeout_hit = (io_cnt == TW'(IO_TIMEOUT - 1));
`endif

    always_comb begin
        if (cpu_adr[31:16] == 16'h0000)
            dec_region = R_RAM;
        else if (cpu_adr[31:16] == 16'h0002)
            dec_region = R_ROM;
        else if (cpu_adr[31:16] == 16'h0003 && cpu_adr[15:10] == 6'd0)
            dec_region = R_IO;
        else
            dec_region = R_NONE;
    end

    // ROM is read-only, so a ROM write is rejected exactly like an unmapped address.
    assign bad_req   = (dec_region == R_NONE) || (dec_region == R_ROM && cpu_wren != 4'h0);
    assign wait_lim  = (region_q == R_ROM) ? WW'(ROM_WAIT) : WW'(RAM_WAIT);
    assign wait_done = (wait_cnt == wait_lim);
    assign is_write  = (wren_q != 4'h0);

    assign ram_adr  = word_q;
    assign rom_adr  = word_q;
    assign io_adr   = word_q[7:0];
    assign ram_do   = data_q;
    assign io_wdata = data_q;
    assign io_wstrb = wren_q;
    assign ram_wren = ram_en ? wren_q : 4'h0;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        next_state  = state;
        ram_en      = 1'b0;
        rom_en      = 1'b0;
        io_valid    = 1'b0;
        cpu_mem_rdy = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_mem_op) begin
                    if (bad_req)
                        next_state = S_RESP;
                    else if (dec_region == R_IO)
                        next_state = S_IO;
                    else
                        next_state = S_MEM;
                end
            end
            S_MEM: begin
                ram_en     = (region_q == R_RAM);
                rom_en     = (region_q == R_ROM);
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done)
                    next_state = S_RESP;
            end
            S_IO: begin
                io_valid = 1'b1;
                if (io_ready)
                    next_state = S_RESP;
`ifdef MEM_BUS_TIMEOUT_EN
                else if (timeout_hit)
                    next_state = S_RESP;
`endif
            end
            S_RESP: begin
                cpu_mem_rdy = 1'b1;
                next_state  = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            region_q <= R_NONE;
            word_q   <= '0;
            data_q   <= '0;
            wren_q   <= '0;
            wait_cnt <= '0;
            cpu_di   <= '0;
            bus_err  <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            io_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_mem_op) begin
                        region_q <= dec_region;
                        word_q   <= cpu_adr[15:2];
                        data_q   <= cpu_do;
                        wren_q   <= cpu_wren;
                        wait_cnt <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
                        io_cnt   <= '0;
`endif
                        if (bad_req) begin
                            cpu_di  <= '0;
                            bus_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // The memories hold their read register, so capturing on the last wait edge is safe.
                    if (wait_done)
                        cpu_di <= is_write ? 32'h0 : ((region_q == R_ROM) ? rom_di : ram_di);
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                S_IO: begin
                    if (io_ready)
                        cpu_di <= is_write ? 32'h0 : io_rdata;
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (timeout_hit) begin
                        cpu_di  <= 32'hFFFF_FFFF;
                        bus_err <= 1'b1;
                    end else
                        io_cnt <= io_cnt + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: the driver queues expected responses, a monitor checks each cpu_mem_rdy.
// Also covers the MEM_BUS_TIMEOUT_EN build when that macro is defined.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_op;
    logic        cpu_mem_rdy;
    logic [31:0] cpu_adr, cpu_do, cpu_di;
    logic [3:0]  cpu_wren;
    logic        ram_en, rom_en, io_valid, bus_err;
    logic [13:0] ram_adr, rom_adr;
    logic [3:0]  ram_wren, io_wstrb;
    logic [31:0] ram_do, ram_di, rom_di, io_wdata, io_rdata;
    logic [7:0]  io_adr;
    logic        io_ready = 1'b0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.RAM_WAIT(0), .ROM_WAIT(1), .IO_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_op(cpu_mem_op), .cpu_mem_rdy(cpu_mem_rdy),
        .cpu_adr(cpu_adr), .cpu_do(cpu_do), .cpu_wren(cpu_wren), .cpu_di(cpu_di),
        .ram_en(ram_en), .ram_adr(ram_adr), .ram_wren(ram_wren), .ram_do(ram_do), .ram_di(ram_di),
        .rom_en(rom_en), .rom_adr(rom_adr), .rom_di(rom_di),
        .io_valid(io_valid), .io_adr(io_adr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
        .io_ready(io_ready), .io_rdata(io_rdata),
        .bus_err(bus_err)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        int          lat;
        logic        err;
        int          accept;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   io_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM model: synchronous read, byte-strobed write, output register holds between accesses.
    logic [31:0] ram_mem [0:16383];
    logic [13:0] last_ram_adr = '0;
    int          ram_total = 0;
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_wren[b]) ram_mem[ram_adr][8*b +: 8] <= ram_do[8*b +: 8];
            ram_di       <= ram_mem[ram_adr];
            last_ram_adr <= ram_adr;
            ram_total    <= ram_total + 1;
        end
    end

    logic [13:0] last_rom_adr = '0;
    int          rom_total = 0;
    always @(posedge clk) begin
        if (rom_en) begin
            rom_di       <= 32'hC0DE_0000 | {18'd0, rom_adr};
            last_rom_adr <= rom_adr;
            rom_total    <= rom_total + 1;
        end
    end

    // Peripheral model: raises io_ready in the (io_delay+1)-th cycle that io_valid is seen.
    int          io_wait = 0;
    int          io_total = 0;
    logic [7:0]  last_io_adr = '0;
    logic [31:0] last_io_wdata = '0;
    logic [3:0]  last_io_wstrb = '0;
    always @(negedge clk) begin
        if (io_valid) begin
            io_ready      <= (io_wait == io_delay);
            io_wait       <= io_wait + 1;
            io_total      <= io_total + 1;
            last_io_adr   <= io_adr;
            last_io_wdata <= io_wdata;
            last_io_wstrb <= io_wstrb;
        end else begin
            io_ready <= 1'b0;
            io_wait  <= 0;
        end
    end

    always @(negedge clk) begin
        if (reset && cpu_mem_rdy) begin
            check("rdy_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, cpu_di, e.data);
                check({e.name, "_lat"}, 32'(cyc - e.accept + 1), 32'(e.lat));
                check({e.name, "_err"}, {31'd0, bus_err}, {31'd0, e.err});
            end
        end
    end

    task automatic issue(input string name, input logic [31:0] adr, input logic [31:0] data,
                         input logic [3:0] wren, input logic [31:0] exp_data, input int exp_lat,
                         input logic exp_err);
        int n;
        @(negedge clk);
        cpu_adr    = adr;
        cpu_do     = data;
        cpu_wren   = wren;
        cpu_mem_op = 1'b1;
        sb.push_back('{name: name, data: exp_data, lat: exp_lat, err: exp_err, accept: cyc + 1});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_mem_rdy && n < 100);
        if (!cpu_mem_rdy) begin
            checks++;
            errors++;
            $display("FAIL %s_rdy_timeout: no cpu_mem_rdy after %0d cycles", name, n);
            sb.delete();
        end
        cpu_mem_op = 1'b0;
        cpu_wren   = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, m0, i0;
        reset      = 1'b0;
        cpu_mem_op = 1'b0;
        cpu_adr    = '0;
        cpu_do     = '0;
        cpu_wren   = '0;
        io_rdata   = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy", {31'd0, cpu_mem_rdy}, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_cpu_di", cpu_di, 32'd0);
        check("rst_enables", {29'd0, ram_en, rom_en, io_valid}, 32'd0);
        reset = 1'b1;

        issue("ram_wr", 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0, 3, 1'b0);
        check("ram_adr", 32'(last_ram_adr), 32'h400);
        check("ram_mem", ram_mem[14'h400], 32'h1234_5678);
        issue("ram_rd", 32'h0000_1000, 32'h0, 4'h0, 32'h1234_5678, 3, 1'b0);
        issue("ram_bwr", 32'h0000_1000, 32'hAABB_CCDD, 4'b0101, 32'h0, 3, 1'b0);
        issue("ram_rd2", 32'h0000_1003, 32'h0, 4'h0, 32'h12BB_56DD, 3, 1'b0);

        issue("rom_rd", 32'h0002_0004, 32'h0, 4'h0, 32'hC0DE_0001, 4, 1'b0);
        check("rom_adr", 32'(last_rom_adr), 32'h1);

        io_delay = 5;
        io_rdata = 32'hA5A5_A5A5;
        i0 = io_total;
        issue("io_rd", 32'h0003_0010, 32'h0, 4'h0, 32'hA5A5_A5A5, 7, 1'b0);
        check("io_adr", 32'(last_io_adr), 32'h04);
        check("io_valid_cycles", 32'(io_total - i0), 32'd6);

        io_delay = 0;
        issue("io_wr", 32'h0003_0020, 32'h5A5A_0F0F, 4'h3, 32'h0, 2, 1'b0);
        check("io_wr_adr", 32'(last_io_adr), 32'h08);
        check("io_wr_data", last_io_wdata, 32'h5A5A_0F0F);
        check("io_wr_strb", 32'(last_io_wstrb), 32'h3);

        issue("rom_rd2", 32'h0002_0008, 32'h0, 4'h0, 32'hC0DE_0002, 4, 1'b0);
        r0 = ram_total;
        m0 = rom_total;
        i0 = io_total;
        issue("unmap_rd", 32'h0005_0000, 32'h0, 4'h0, 32'h0, 1, 1'b1);
        issue("rom_wr", 32'h0002_0000, 32'h0000_FFFF, 4'hF, 32'h0, 1, 1'b1);
        issue("io_hole", 32'h0003_0400, 32'h0, 4'h0, 32'h0, 1, 1'b1);
        check("unmap_ram_en", 32'(ram_total - r0), 32'd0);
        check("unmap_rom_en", 32'(rom_total - m0), 32'd0);
        check("unmap_io_valid", 32'(io_total - i0), 32'd0);
        issue("ram_rd_sticky", 32'h0000_1000, 32'h0, 4'h0, 32'h12BB_56DD, 3, 1'b1);

        // Reset in the middle of a stalled peripheral access.
        io_delay = 1000;
        @(negedge clk);
        cpu_adr    = 32'h0003_0010;
        cpu_wren   = 4'h0;
        cpu_mem_op = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_io_busy", {31'd0, io_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_io_valid", {31'd0, io_valid}, 32'd0);
        check("rst_mid_rdy", {31'd0, cpu_mem_rdy}, 32'd0);
        check("rst_mid_err", {31'd0, bus_err}, 32'd0);
        check("rst_mid_cpu_di", cpu_di, 32'd0);
        cpu_mem_op = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        issue("post_rst_rd", 32'h0000_1000, 32'h0, 4'h0, 32'h12BB_56DD, 3, 1'b0);

`ifdef MEM_BUS_TIMEOUT_EN
        i0 = io_total;
        issue("io_timeout", 32'h0003_0010, 32'h0, 4'h0, 32'hFFFF_FFFF, 9, 1'b1);
        check("io_timeout_cycles", 32'(io_total - i0), 32'd8);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
